// File: rtl/usart_rx.sv
// usart_rx: oversampling UART receive stage with majority-vote bit decode and
// a 2-entry receive buffer carrying per-frame framing/parity error flags.
module usart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_en,
    input  logic [1:0]           parity_mode,
    input  logic                 rx,
    input  logic                 rx_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 fe,
    output logic                 pe,
    output logic                 dor,
    output logic                 rx_busy
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int ENT_W = DATA_BITS + 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    logic                 rx_meta_r;
    logic                 rx_sync_r;
    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic [1:0]           samp_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_en_r;
    logic                 par_odd_r;
    logic                 pe_flag_r;
    logic                 busy_r;

    logic [ENT_W-1:0]     head_r;
    logic [ENT_W-1:0]     tail_r;
    logic                 head_vld_r;
    logic                 tail_vld_r;
    logic                 dor_r;

    logic                 vote_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 overrun_s;
    logic [ENT_W-1:0]     new_entry_s;
    logic [ENT_W-1:0]     mid_head_s;
    logic [ENT_W-1:0]     mid_tail_s;
    logic                 mid_head_vld_s;
    logic                 mid_tail_vld_s;
    logic [ENT_W-1:0]     head_n_s;
    logic [ENT_W-1:0]     tail_n_s;
    logic                 head_vld_n_s;
    logic                 tail_vld_n_s;

    assign vote_s      = maj3(samp_r[0], samp_r[1], rx_sync_r);
    assign push_s      = rx_en && baud_tick && (state_r == ST_STOP) && (cnt_r == SMP_C);
    assign new_entry_s = {shift_r, ~vote_s, pe_flag_r};

    // Two-flop synchronizer for the asynchronous rx line; idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Bit-timing FSM: start detect, per-bit majority vote, frame assembly
    always_ff @(posedge clk) begin
        if (rst || !rx_en) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= '0;
            samp_r    <= 2'b00;
            shift_r   <= '0;
            par_en_r  <= 1'b0;
            par_odd_r <= 1'b0;
            pe_flag_r <= 1'b0;
            busy_r    <= 1'b0;
        end else if (baud_tick) begin
            if (state_r == ST_IDLE) begin
                if (!rx_sync_r) begin
                    state_r   <= ST_START;
                    cnt_r     <= CNT_W'(1);
                    bit_idx_r <= '0;
                    busy_r    <= 1'b1;
                    pe_flag_r <= 1'b0;
                    par_en_r  <= parity_mode[1];
                    par_odd_r <= parity_mode[0];
                end
            end else begin
                cnt_r <= (cnt_r == CNT_MAX) ? '0 : cnt_r + CNT_W'(1);
                if (cnt_r == SMP_A) samp_r[0] <= rx_sync_r;
                if (cnt_r == SMP_B) samp_r[1] <= rx_sync_r;
                if (cnt_r == SMP_C) begin
                    case (state_r)
                        ST_START: begin
                            if (vote_s) begin
                                state_r <= ST_IDLE;
                                cnt_r   <= '0;
                                busy_r  <= 1'b0;
                            end else begin
                                state_r <= ST_DATA;
                            end
                        end
                        ST_DATA: begin
                            shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
                            if (bit_idx_r == IDX_LAST) begin
                                state_r <= par_en_r ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_idx_r <= bit_idx_r + IDX_W'(1);
                            end
                        end
                        ST_PARITY: begin
                            pe_flag_r <= (vote_s != (parity_of(shift_r) ^ par_odd_r));
                            state_r   <= ST_STOP;
                        end
                        ST_STOP: begin
                            // Frame completes mid stop bit so a new start is seen promptly
                            state_r <= ST_IDLE;
                            cnt_r   <= '0;
                            busy_r  <= 1'b0;
                        end
                        default: begin
                            state_r <= ST_IDLE;
                            cnt_r   <= '0;
                            busy_r  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Buffer view after the pop; an emptied slot is zeroed so outputs read 0
    always_comb begin
        pop_s = rx_read && head_vld_r;
        if (pop_s) begin
            mid_head_s     = tail_r;
            mid_head_vld_s = tail_vld_r;
            mid_tail_s     = '0;
            mid_tail_vld_s = 1'b0;
        end else begin
            mid_head_s     = head_r;
            mid_head_vld_s = head_vld_r;
            mid_tail_s     = tail_r;
            mid_tail_vld_s = tail_vld_r;
        end
    end

    // Push lands in the first free slot, otherwise the new frame is dropped
    always_comb begin
        head_n_s     = mid_head_s;
        head_vld_n_s = mid_head_vld_s;
        tail_n_s     = mid_tail_s;
        tail_vld_n_s = mid_tail_vld_s;
        overrun_s    = 1'b0;
        if (push_s && !mid_head_vld_s) begin
            head_n_s     = new_entry_s;
            head_vld_n_s = 1'b1;
        end else if (push_s && !mid_tail_vld_s) begin
            tail_n_s     = new_entry_s;
            tail_vld_n_s = 1'b1;
        end else if (push_s) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = 1'b0;
        end
    end

    // Receive buffer and sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst || !rx_en) begin
            head_r     <= '0;
            tail_r     <= '0;
            head_vld_r <= 1'b0;
            tail_vld_r <= 1'b0;
            dor_r      <= 1'b0;
        end else begin
            head_r     <= head_n_s;
            tail_r     <= tail_n_s;
            head_vld_r <= head_vld_n_s;
            tail_vld_r <= tail_vld_n_s;
            dor_r      <= overrun_s ? 1'b1 : (pop_s ? 1'b0 : dor_r);
        end
    end

    assign rx_data  = head_r[ENT_W-1:2];
    assign fe       = head_r[1];
    assign pe       = head_r[0];
    assign rx_valid = head_vld_r;
    assign dor      = dor_r;
    assign rx_busy  = busy_r;

endmodule

// File: doc/usart_rx.md
Name: usart_rx

Overview:
- Asynchronous receive stage of the USART. It consumes the serial rx line driven on the UART interface and produces parallel bytes for the register/bus side.
- Oversamples rx using a baud-rate tick from the clock generator and decodes start/data/parity/stop.
- Pushes each frame, with its error flags, into a 2-entry receive buffer that is read through a pop strobe.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8), LSB first
- OVERSAMPLE, 16, baud_tick pulses per bit period

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- baud_tick  input  1  one-clk pulse, OVERSAMPLE per bit period
- rx_en  input  1  receiver enable
- parity_mode  input  2  00 none, 01 reserved (treated as none), 10 even, 11 odd
- rx  input  1  serial input, asynchronous, idle high
- rx_read  input  1  pop strobe for the buffer head
- rx_data  output  DATA_BITS  head-entry data
- rx_valid  output  1  buffer non-empty
- fe  output  1  head-entry frame error
- pe  output  1  head-entry parity error
- dor  output  1  data overrun, sticky
- rx_busy  output  1  frame in progress

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset values: all outputs 0, FSM in IDLE, buffer empty, sample counter 0, synchronizer flops 1.
- Input synchronizer: rx passes through a 2-flop synchronizer (rx_s). All decoding uses rx_s only.
- Sample counter: 0..OVERSAMPLE-1. Advances only on baud_tick.
- Bit voting: bit value is the majority of samples 7, 8, 9. Evaluated on the tick of sample 9; counter wraps at 15.
- FSM:
  - IDLE: rx_s=0 on a baud_tick -> START, counter=1.
  - START: at sample 9, vote=1 -> IDLE (false start, no flags). Vote=0 -> DATA, bit index 0.
  - DATA: one vote per bit, shifted in LSB first. After bit DATA_BITS-1 -> PARITY if parity enabled, else STOP.
  - PARITY: vote compared with XOR of the data bits (even) or its inverse (odd). A mismatch sets the frame's pe.
  - STOP: at sample 9 of the first stop bit, vote=0 sets the frame's fe. The frame is pushed and the FSM returns to IDLE on the same tick. The FSM does not wait for the stop-bit end; a new start can be detected from the next tick.
- Latency: rx_valid rises the clk after the stop-bit vote tick.
- rx_busy: 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Buffer: 2 entries of {data, fe, pe}. Outputs always show the head entry and are 0 when empty. rx_read pops the head; rx_read while empty is ignored.
- Simultaneous push and pop:
  - Pop is applied first.
  - A push is never lost when rx_read coincides with a full buffer.
  - Push+pop on an empty buffer: the pushed frame becomes the head; no effect from rx_read.
- Overrun:
  - A push with the buffer full and no rx_read discards the new frame and sets dor.
  - dor clears on the next accepted rx_read.
  - If a new overrun occurs on the same clk as that read, the overrun wins.
- rx_en=0: FSM forced to IDLE, buffer flushed, dor cleared, all within one clk. It stays this way while low. rx_s is still tracked.
- Reset mid-frame: returns to the reset state on the next clk edge. The partial frame is discarded.
- parity_mode changes are only required to take effect from the next START.

Test Plan:
- OVERSAMPLE=16, baud_tick every 4 clk, parity none; send frame 0xA5 with 1 stop bit -> rx_valid=1, rx_data=0xA5, fe=0, pe=0. rx_read -> rx_valid=0 on the next clk.
- parity_mode=10; send 0x03 with parity bit 1 (wrong) -> rx_data=0x03, pe=1. Resend with parity bit 0 -> pe=0.
- rx low for 4 ticks, then high -> no push, rx_busy pulses then returns to 0, rx_valid stays 0.
- Send 0x55 with stop bit 0 -> rx_data=0x55, fe=1. The next frame 0x66, sent immediately after, is received correctly with fe=0.
- Overrun: send 0x11, 0x22, 0x33 without reads -> head 0x11, dor=1. Pop -> head 0x22, dor=0. Pop -> rx_valid=0, 0x33 was never stored.
- Full buffer with rx_read asserted on the stop-vote clk of a third frame 0x44 -> buffer holds 0x22, 0x44, dor=0.
- Assert rst during DATA of frame 0x7E -> all outputs 0 the next clk and no push. The following frame 0x81 is received correctly.
